// File: rtl/adc_pkg.sv
// Shared definitions for the dual-channel serial ADC reader: FSM states,
// frame geometry and counter widths.
package adc_pkg;

    localparam int FRAME_LEN   = 34;
    localparam int A_OFFSET    = 2;
    localparam int B_OFFSET    = 18;
    localparam int SAMPLE_W    = 14;
    localparam int CONV_W      = 2;
    localparam int BIT_CNT_W   = 6;
    localparam int PHASE_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        SHIFT  = 2'd2,
        FINISH = 2'd3
    } adc_state_t;

    // True when frame bit k belongs to the 14-bit field starting at offset.
    function automatic logic in_field(input logic [BIT_CNT_W-1:0] k, input int offset);
        return (int'(k) >= offset) && (int'(k) < offset + SAMPLE_W);
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock generator: DIV cycles low then DIV cycles high per period,
// FRAME_LEN periods per frame, with sample and end-of-frame strobes.
module adc_sck_gen
    import adc_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 sck,
    output logic                 rise,
    output logic                 last,
    output logic [BIT_CNT_W-1:0] bit_idx
);

    localparam logic [PHASE_CNT_W-1:0] PHASE_END = PHASE_CNT_W'(DIV - 1);
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT  = BIT_CNT_W'(FRAME_LEN - 1);

    logic [PHASE_CNT_W-1:0] phase_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   sck_r;
    logic                   running;
    logic                   phase_end;

    assign phase_end = running && (phase_cnt == PHASE_END);
    assign rise      = phase_end && !sck_r;
    assign last      = phase_end && sck_r && (bit_cnt == LAST_BIT);
    assign sck       = sck_r;
    assign bit_idx   = bit_cnt;

    // Phase/period counters; the first enabled cycle only arms the first low phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sck_r     <= 1'b1;
            running   <= 1'b0;
        end else if (!en || last) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sck_r     <= 1'b1;
            running   <= 1'b0;
        end else if (!running) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            sck_r     <= 1'b0;
            running   <= 1'b1;
        end else if (phase_end) begin
            phase_cnt <= '0;
            if (!sck_r) begin
                sck_r   <= 1'b1;
                bit_cnt <= bit_cnt;
            end else begin
                sck_r   <= 1'b0;
                bit_cnt <= bit_cnt + 6'd1;
            end
        end else begin
            phase_cnt <= phase_cnt + 8'd1;
            bit_cnt   <= bit_cnt;
            sck_r     <= sck_r;
        end
    end

endmodule

// File: rtl/adc_reader.sv
// Dual-channel serial ADC reader: start strobe, 34-bit SCK frame, two 14-bit
// samples. Optional sticky overrun flag under `ADC_READER_OVERRUN_EN.
module adc_reader
    import adc_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic                CLK50MHZ,
    input  logic                RST,
    input  logic                trig,
    output logic                done,
    output logic                busy,
    output logic [SAMPLE_W-1:0] a,
    output logic [SAMPLE_W-1:0] b,
    output logic                ad_conv,
    output logic                spi_sck,
    input  logic                spi_miso
`ifdef ADC_READER_OVERRUN_EN
    ,
    output logic                overrun
`endif
);

    localparam logic [1:0] CONV_END = 2'(CONV_W - 1);

    adc_state_t            state;
    adc_state_t            next_state;
    logic [1:0]            conv_cnt;
    logic [SAMPLE_W-1:0]   a_sh;
    logic [SAMPLE_W-1:0]   b_sh;
    logic [SAMPLE_W-1:0]   a_r;
    logic [SAMPLE_W-1:0]   b_r;
    logic                  done_r;
    logic                  busy_r;
    logic                  ad_conv_r;
    logic                  sck_rise;
    logic                  sck_last;
    logic [BIT_CNT_W-1:0]  bit_idx;

    adc_sck_gen #(
        .DIV (DIV)
    ) u_sck_gen (
        .clk     (CLK50MHZ),
        .rst     (RST),
        .en      (state == SHIFT),
        .sck     (spi_sck),
        .rise    (sck_rise),
        .last    (sck_last),
        .bit_idx (bit_idx)
    );

    // Next-state decode; trig is only looked at in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (trig) next_state = CONV;
                else      next_state = IDLE;
            end
            CONV: begin
                if (conv_cnt == CONV_END) next_state = SHIFT;
                else                      next_state = CONV;
            end
            SHIFT: begin
                if (sck_last) next_state = FINISH;
                else          next_state = SHIFT;
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, CONV length counter and state-aligned registered strobes.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            conv_cnt  <= 2'd0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            ad_conv_r <= 1'b0;
        end else begin
            state     <= next_state;
            conv_cnt  <= (state == CONV) ? conv_cnt + 2'd1 : 2'd0;
            done_r    <= (next_state == FINISH);
            busy_r    <= (next_state != IDLE);
            ad_conv_r <= (next_state == CONV);
        end
    end

    // Shift each channel field MSB first; publish both only on FINISH entry.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            a_sh <= '0;
            b_sh <= '0;
            a_r  <= '0;
            b_r  <= '0;
        end else begin
            if (sck_rise && in_field(bit_idx, A_OFFSET)) a_sh <= {a_sh[SAMPLE_W-2:0], spi_miso};
            else                                         a_sh <= a_sh;
            if (sck_rise && in_field(bit_idx, B_OFFSET)) b_sh <= {b_sh[SAMPLE_W-2:0], spi_miso};
            else                                         b_sh <= b_sh;
            if (next_state == FINISH) begin
                a_r <= a_sh;
                b_r <= b_sh;
            end else begin
                a_r <= a_r;
                b_r <= b_r;
            end
        end
    end

`ifdef ADC_READER_OVERRUN_EN
    logic overrun_r;

    // Sticky record of any trigger that arrived while a frame was in flight.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST)                  overrun_r <= 1'b0;
        else if (trig && busy_r)  overrun_r <= 1'b1;
        else                      overrun_r <= overrun_r;
    end

    assign overrun = overrun_r;
`endif

    assign done    = done_r;
    assign busy    = busy_r;
    assign ad_conv = ad_conv_r;
    assign a       = a_r;
    assign b       = b_r;

endmodule

// File: tb/tb_adc_reader.sv
// Directed scoreboard bench for adc_reader: instance 0 uses DIV=2, instance 1 DIV=1,
// each fed by a behavioural converter model on spi_miso.
module tb_adc_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        trig_s [2];
    logic        done_s [2];
    logic        busy_s [2];
    logic [13:0] a_s    [2];
    logic [13:0] b_s    [2];
    logic        conv_s [2];
    logic        sck_s  [2];
    logic        miso_s [2];
`ifdef ADC_READER_OVERRUN_EN
    logic        ovr_s  [2];
`endif

    logic [33:0] frame_m [2];
    int          bitk    [2];
    int          rises   [2];
    int          total = 0;
    int          bad   = 0;

    typedef struct { logic [13:0] a; logic [13:0] b; } samp_t;
    samp_t sb[$];

    always #10 clk = ~clk;

    adc_reader #(.DIV(2)) dut2 (
        .CLK50MHZ (clk), .RST (rst), .trig (trig_s[0]), .done (done_s[0]), .busy (busy_s[0]),
        .a (a_s[0]), .b (b_s[0]), .ad_conv (conv_s[0]), .spi_sck (sck_s[0]), .spi_miso (miso_s[0])
`ifdef ADC_READER_OVERRUN_EN
        , .overrun (ovr_s[0])
`endif
    );

    adc_reader #(.DIV(1)) dut1 (
        .CLK50MHZ (clk), .RST (rst), .trig (trig_s[1]), .done (done_s[1]), .busy (busy_s[1]),
        .a (a_s[1]), .b (b_s[1]), .ad_conv (conv_s[1]), .spi_sck (sck_s[1]), .spi_miso (miso_s[1])
`ifdef ADC_READER_OVERRUN_EN
        , .overrun (ovr_s[1])
`endif
    );

    // Converter models: bit k appears on the falling SCK edge that opens period k.
    always @(posedge conv_s[0] or negedge sck_s[0]) begin
        if (conv_s[0]) bitk[0] = 0;
        else if (bitk[0] < 34) begin
            miso_s[0] = frame_m[0][33 - bitk[0]];
            bitk[0]++;
        end
    end

    always @(posedge conv_s[1] or negedge sck_s[1]) begin
        if (conv_s[1]) bitk[1] = 0;
        else if (bitk[1] < 34) begin
            miso_s[1] = frame_m[1][33 - bitk[1]];
            bitk[1]++;
        end
    end

    always @(posedge sck_s[0]) rises[0]++;
    always @(posedge sck_s[1]) rises[1]++;

    function automatic logic [33:0] build(input logic [13:0] sa, input logic [13:0] sbv, input logic d);
        return {{2{d}}, sa, {2{d}}, sbv, {2{d}}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst_done",  32'(done_s[u]), 32'd0);
        chk("rst_busy",  32'(busy_s[u]), 32'd0);
        chk("rst_conv",  32'(conv_s[u]), 32'd0);
        chk("rst_sck",   32'(sck_s[u]),  32'd1);
        chk("rst_a",     32'(a_s[u]),    32'd0);
        chk("rst_b",     32'(b_s[u]),    32'd0);
    endtask

    // One full frame on instance u; call at a negedge. Optional retrigger and hold check.
    task automatic run_frame(input int u, input logic [13:0] ea, input logic [13:0] eb,
                             input logic dmy, input int retrig_at,
                             input logic chk_hold, input logic [13:0] ha, input logic [13:0] hb);
        int    lat;
        int    convs;
        int    r0;
        int    exp_lat;
        samp_t e;
        exp_lat    = 3 + 68 * ((u == 0) ? 2 : 1);
        frame_m[u] = build(ea, eb, dmy);
        sb.push_back('{ea, eb});
        r0         = rises[u];
        trig_s[u]  = 1'b1;
        @(negedge clk);
        trig_s[u]  = 1'b0;
        chk("busy_after_trig", 32'(busy_s[u]), 32'd1);
        convs = conv_s[u] ? 1 : 0;
        lat   = 0;
        while (lat < 400 && !done_s[u]) begin
            @(negedge clk);
            lat++;
            if (conv_s[u]) convs++;
            if (retrig_at != 0 && lat == retrig_at) trig_s[u] = 1'b1;
            else                                    trig_s[u] = 1'b0;
            if (chk_hold && lat == 70) begin
                chk("hold_a", 32'(a_s[u]), 32'(ha));
                chk("hold_b", 32'(b_s[u]), 32'(hb));
            end
        end
        chk("done_latency", 32'(lat), 32'(exp_lat));
        e = sb.pop_front();
        if (done_s[u]) begin
            chk("sample_a", 32'(a_s[u]), 32'(e.a));
            chk("sample_b", 32'(b_s[u]), 32'(e.b));
        end
        chk("ad_conv_cycles", 32'(convs), 32'd2);
        chk("sck_periods", 32'(rises[u] - r0), 32'd34);
        @(negedge clk);
        chk("done_single", 32'(done_s[u]), 32'd0);
        chk("busy_after_done", 32'(busy_s[u]), 32'd0);
    endtask

    initial begin
        int ndone;
        rst       = 1'b1;
        trig_s[0] = 1'b0;
        trig_s[1] = 1'b0;
        miso_s[0] = 1'b0;
        miso_s[1] = 1'b0;
        bitk[0]   = 0;
        bitk[1]   = 0;
        rises[0]  = 0;
        rises[1]  = 0;
        frame_m[0] = '0;
        frame_m[1] = '0;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        @(negedge clk);

        // Nominal sample, sign extremes with dummy bits high, back-to-back frames.
        run_frame(0, 14'h1ABC, 14'h2345, 1'b0, 0, 1'b0, 14'h0000, 14'h0000);
        run_frame(0, 14'h2000, 14'h1FFF, 1'b1, 0, 1'b0, 14'h0000, 14'h0000);
        run_frame(0, 14'h0155, 14'h3EAA, 1'b0, 0, 1'b0, 14'h0000, 14'h0000);
        run_frame(0, 14'h3FFF, 14'h0001, 1'b1, 0, 1'b1, 14'h0155, 14'h3EAA);

        // Retrigger 40 cycles in must be ignored: one done, then silence.
        run_frame(0, 14'h0ABC, 14'h1234, 1'b0, 40, 1'b0, 14'h0000, 14'h0000);
        ndone = 0;
        repeat (200) begin
            @(negedge clk);
            if (done_s[0]) ndone++;
        end
        chk("no_extra_done", 32'(ndone), 32'd0);
`ifdef ADC_READER_OVERRUN_EN
        chk("overrun_set", 32'(ovr_s[0]), 32'd1);
        chk("overrun_clear_other", 32'(ovr_s[1]), 32'd0);
`endif

        // Reset 70 cycles into a frame: immediate reset values, no done afterwards.
        frame_m[0] = build(14'h0F0F, 14'h30F0, 1'b0);
        trig_s[0]  = 1'b1;
        @(negedge clk);
        trig_s[0]  = 1'b0;
        repeat (70) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset(0);
`ifdef ADC_READER_OVERRUN_EN
        chk("overrun_reset", 32'(ovr_s[0]), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (150) begin
            @(negedge clk);
            if (done_s[0]) ndone++;
        end
        chk("no_done_after_abort", 32'(ndone), 32'd0);
        run_frame(0, 14'h1357, 14'h2468, 1'b1, 0, 1'b0, 14'h0000, 14'h0000);

        // Fastest serial clock.
        run_frame(1, 14'h1ABC, 14'h2345, 1'b0, 0, 1'b0, 14'h0000, 14'h0000);
        run_frame(1, 14'h2000, 14'h1FFF, 1'b1, 0, 1'b1, 14'h1ABC, 14'h2345);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
